// File: rtl/fft_framer.sv
// fft_framer: captures a (optionally decimated) frame of FRAME_LEN samples into a buffer,
// then replays it as an AXI-Stream burst with tlast on the final sample.
module fft_framer #(
   parameter int DW = 16,
   parameter int FRAME_LEN = 1024,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [DW-1:0] s_tdata,
   input  logic          s_tvalid,
   output logic          s_tready,
   output logic [DW-1:0] m_tdata,
   output logic          m_tvalid,
   output logic          m_tlast,
   input  logic          m_tready,
   input  logic          ctrl_en,
   input  logic          ctrl_cont,
   input  logic          ctrl_arm,
   input  logic [7:0]    ctrl_decim,
   output logic          sts_busy,
   output logic [15:0]   sts_frames,
   output logic [15:0]   sts_drops
);
   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
   state_t state;
   logic [DW-1:0] ram [FRAME_LEN];
   logic [AW-1:0] wr_idx, rd_idx;
   logic [7:0] dcnt, decim_r;
   logic keep, load;

   assign s_tready = 1'b1;
   assign sts_busy = state != IDLE;
   assign keep = state == FILL && ctrl_en && s_tvalid && dcnt == '0;
   // fetch the next word whenever the output register is empty or being consumed; stop once tlast is loaded
   assign load = state == DRAIN && (!m_tvalid || m_tready) && !m_tlast;

   always_ff @(posedge clk)
      if (keep) ram[wr_idx] <= s_tdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         wr_idx     <= '0;
         rd_idx     <= '0;
         dcnt       <= '0;
         decim_r    <= '0;
         m_tdata    <= '0;
         m_tvalid   <= 1'b0;
         m_tlast    <= 1'b0;
         sts_frames <= '0;
         sts_drops  <= '0;
      end else begin
         if (state == DRAIN && s_tvalid && sts_drops != '1) sts_drops <= sts_drops + 16'd1;
         if (load) begin
            m_tdata  <= ram[rd_idx];
            m_tvalid <= 1'b1;
            m_tlast  <= rd_idx == AW'(FRAME_LEN - 1);
            rd_idx   <= rd_idx + 1'b1;
         end else if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
         end
         case (state)
            IDLE: begin
               decim_r <= ctrl_decim;
               if (ctrl_en && (ctrl_cont || ctrl_arm)) begin
                  state  <= FILL;
                  wr_idx <= '0;
                  dcnt   <= '0;
               end
            end
            FILL: begin
               if (!ctrl_en) state <= IDLE;
               else if (s_tvalid) begin
                  dcnt <= dcnt == decim_r ? 8'd0 : dcnt + 8'd1;
                  if (dcnt == '0) begin
                     wr_idx <= wr_idx + 1'b1;
                     if (wr_idx == AW'(FRAME_LEN - 1)) state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (m_tvalid && m_tready && m_tlast) begin
                  sts_frames <= sts_frames + 16'd1;
                  state      <= ctrl_en && ctrl_cont ? FILL : IDLE;
                  wr_idx     <= '0;
                  dcnt       <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fft_framer.sv
// tb_fft_framer: directed tests of fft_framer (FRAME_LEN=16) against a frame-level reference model.
module tb_fft_framer;
   localparam int DW = 16;
   localparam int N  = 16;
   localparam int AW = 4;

   logic clk = 1'b0, reset_n = 1'b0;
   logic [DW-1:0] s_tdata = '0, m_tdata;
   logic s_tvalid = 1'b0, s_tready, m_tvalid, m_tlast, m_tready = 1'b1;
   logic ctrl_en = 1'b0, ctrl_cont = 1'b0, ctrl_arm = 1'b0;
   logic [7:0] ctrl_decim = '0;
   logic sts_busy;
   logic [15:0] sts_frames, sts_drops;

   always #5 clk = ~clk;

   fft_framer #(.DW(DW), .FRAME_LEN(N), .AW(AW)) dut (
      .clk(clk), .reset_n(reset_n),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .ctrl_en(ctrl_en), .ctrl_cont(ctrl_cont), .ctrl_arm(ctrl_arm), .ctrl_decim(ctrl_decim),
      .sts_busy(sts_busy), .sts_frames(sts_frames), .sts_drops(sts_drops)
   );

   int checks = 0, errors = 0;
   int got[$];
   int nlast = 0, cyc = 0, first_v = -1, t_watch = -1, watch = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 idle, 1 fill, 2 drain; frame holds kept samples, k is the presented index.
   int mode = 0, dc = 0, dr = 0, k = 0, frames = 0, drops = 0;
   bit ev = 0;
   int frame[$];

   task automatic model_step();
      if (!reset_n) begin
         mode = 0; dc = 0; dr = 0; k = 0; ev = 0; frames = 0; drops = 0;
         frame.delete();
         return;
      end
      cyc++;
      if (mode == 0) begin
         dr = ctrl_decim;
         if (ctrl_en && (ctrl_cont || ctrl_arm)) begin
            mode = 1; dc = 0; frame.delete();
         end
      end else if (mode == 1) begin
         if (!ctrl_en) mode = 0;
         else if (s_tvalid) begin
            if (dc == 0) frame.push_back(int'(s_tdata));
            dc = (dc == dr) ? 0 : dc + 1;
            if (frame.size() == N) begin
               mode = 2; ev = 0; k = 0;
            end
         end
      end else begin
         if (s_tvalid && drops < 65535) drops++;
         if (!ev) begin
            ev = 1; k = 0;
         end else if (m_tready) begin
            if (k == N - 1) begin
               frames++; ev = 0;
               mode = (ctrl_en && ctrl_cont) ? 1 : 0;
               dc = 0; frame.delete();
            end else k++;
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge reset_n);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (reset_n) begin
         chk("m_tvalid", m_tvalid, ev);
         chk("m_tlast", m_tlast, ev && k == N - 1);
         if (ev) chk("m_tdata", m_tdata, frame[k]);
         chk("sts_busy", sts_busy, mode != 0);
         chk("sts_frames", sts_frames, frames[15:0]);
         chk("sts_drops", sts_drops, drops);
         chk("s_tready", s_tready, 1);
         if (m_tvalid && m_tready) begin
            got.push_back(int'(m_tdata));
            if (m_tlast) nlast++;
         end
         if (m_tvalid && first_v < 0) first_v = cyc;
         if (s_tvalid && int'(s_tdata) == watch) t_watch = cyc;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int v, input bit val);
      s_tdata = DW'(v);
      s_tvalid = val;
      step();
   endtask

   task automatic arm();
      s_tvalid = 1'b0;
      ctrl_arm = 1'b1;
      step();
      ctrl_arm = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      int i;
      for (i = 0; i < maxc && (sts_busy || m_tvalid); i++) step();
      if (i == maxc) begin
         errors++;
         $display("FAIL wait_idle: still busy after %0d cycles", maxc);
      end
   endtask

   task automatic clear();
      got.delete();
      nlast = 0;
   endtask

   initial begin
      int v;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_busy", sts_busy, 0);
      chk("rst_frames", sts_frames, 0);
      chk("rst_drops", sts_drops, 0);
      chk("rst_tready", s_tready, 1);
      reset_n = 1'b1;
      step();
      ctrl_en = 1'b1;

      // single shot: 18 samples, the last two arrive during drain
      clear();
      arm();
      for (int i = 0; i < 18; i++) feed(i, 1);
      s_tvalid = 1'b0;
      wait_idle(60);
      chk("ss_count", got.size(), 16);
      for (int i = 0; i < got.size(); i++) chk("ss_data", got[i], i);
      chk("ss_tlast", nlast, 1);
      chk("ss_frames", sts_frames, 1);
      chk("ss_drops", sts_drops, 2);
      for (int i = 0; i < 10; i++) feed(50 + i, 1);
      s_tvalid = 1'b0;
      chk("ss_no_rearm", got.size(), 16);
      chk("ss_idle_drops", sts_drops, 2);
      chk("ss_idle_busy", sts_busy, 0);

      // decimation by 4
      clear();
      ctrl_decim = 8'd3;
      watch = 60;
      first_v = -1;
      arm();
      for (int i = 0; i < 64; i++) feed(i, 1);
      s_tvalid = 1'b0;
      wait_idle(60);
      watch = -1;
      ctrl_decim = 8'd0;
      chk("dec_count", got.size(), 16);
      for (int i = 0; i < got.size(); i++) chk("dec_data", got[i], 4 * i);
      chk("dec_latency", first_v - t_watch, 2);
      chk("dec_tlast", nlast, 1);

      // backpressure
      clear();
      arm();
      for (int i = 0; i < 16; i++) begin
         m_tready = 1'($urandom_range(0, 1));
         feed(100 + i, 1);
      end
      s_tvalid = 1'b0;
      for (int i = 0; i < 300 && (sts_busy || m_tvalid); i++) begin
         m_tready = 1'($urandom_range(0, 1));
         step();
      end
      m_tready = 1'b1;
      wait_idle(40);
      chk("bp_count", got.size(), 16);
      for (int i = 0; i < got.size(); i++) chk("bp_data", got[i], 100 + i);
      chk("bp_tlast", nlast, 1);
      chk("bp_frames", sts_frames, 3);

      // continuous mode, three frames on a gap-free ramp
      clear();
      ctrl_cont = 1'b1;
      s_tvalid = 1'b0;
      step();
      v = 200;
      for (int i = 0; i < 200 && sts_frames != 16'd5; i++) feed(v++, 1);
      ctrl_cont = 1'b0;
      for (int i = 0; i < 200 && sts_frames != 16'd6; i++) feed(v++, 1);
      s_tvalid = 1'b0;
      wait_idle(40);
      chk("cont_frames", sts_frames, 6);
      chk("cont_count", got.size(), 48);
      chk("cont_f0", got.size() > 0 ? got[0] : -1, 200);
      chk("cont_f1", got.size() > 16 ? got[16] : -1, 233);
      chk("cont_f2", got.size() > 32 ? got[32] : -1, 266);
      chk("cont_tlast", nlast, 3);

      // abort after five kept samples
      clear();
      arm();
      for (int i = 0; i < 5; i++) feed(300 + i, 1);
      ctrl_en = 1'b0;
      feed(305, 1);
      ctrl_en = 1'b1;
      for (int i = 0; i < 4; i++) feed(306 + i, 1);
      s_tvalid = 1'b0;
      chk("ab_busy", sts_busy, 0);
      chk("ab_count", got.size(), 0);
      chk("ab_frames", sts_frames, 6);
      arm();
      for (int i = 0; i < 16; i++) feed(400 + i, 1);
      s_tvalid = 1'b0;
      wait_idle(40);
      chk("ab_new_count", got.size(), 16);
      for (int i = 0; i < got.size(); i++) chk("ab_new_data", got[i], 400 + i);
      chk("ab_new_frames", sts_frames, 7);

      // drop counter saturation while drain is stalled, then async reset mid-drain
      clear();
      arm();
      for (int i = 0; i < 16; i++) feed(500 + i, 1);
      m_tready = 1'b0;
      for (int i = 0; i < 70000; i++) feed(i, 1);
      chk("sat_drops", sts_drops, 16'hFFFF);
      chk("sat_hold_valid", m_tvalid, 1);
      chk("sat_hold_data", m_tdata, 500);
      chk("sat_hold_last", m_tlast, 0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_m_tvalid", m_tvalid, 0);
      chk("ar_m_tdata", m_tdata, 0);
      chk("ar_m_tlast", m_tlast, 0);
      chk("ar_busy", sts_busy, 0);
      chk("ar_frames", sts_frames, 0);
      chk("ar_drops", sts_drops, 0);
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) step();
      chk("ar_no_output", got.size(), 0);
      chk("ar_no_tlast", nlast, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
